// File: rtl/fifo_dpram_ctrl_if.sv
// Request/response bundle between transaction-layer producers/consumers and
// the FIFO controller.
interface fifo_dpram_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );
endinterface

// File: rtl/fifo_dpram_ctrl.sv
// FIFO controller driving an external 64x8 true dual-port RAM: writes on
// port A, reads on port B (registered read data returned on q_b).
module fifo_dpram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_TH      = 60,
  parameter int AE_TH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_dpram_ctrl_if.slave      bus,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  input  logic [DATA_WIDTH-1:0] q_b
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt;
  logic                  full_r;
  logic                  empty_r;
  logic                  af_r;
  logic                  ae_r;
  logic                  valid_r;
  logic                  error_r;
  logic                  push_ok;
  logic                  pop_ok;

  // Push on full is refused even alongside a pop so port A never writes the
  // address port B is reading.
  assign push_ok = bus.push & ~full_r & ~reset;
  assign pop_ok  = bus.pop & ~empty_r & ~reset;

  assign we_a   = push_ok;
  assign addr_a = wr_ptr;
  assign data_a = bus.data_in;
  assign we_b   = 1'b0;
  assign addr_b = rd_ptr;
  assign data_b = '0;

  always_comb begin
    count_nxt = count_r;
    if (push_ok && !pop_ok)
      count_nxt = count_r + CW'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count_r - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
      valid_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count_r <= count_nxt;
      full_r  <= (count_nxt == DEPTH);
      empty_r <= (count_nxt == '0);
      af_r    <= (count_nxt >= CW'(AF_TH));
      ae_r    <= (count_nxt <= CW'(AE_TH));
      valid_r <= pop_ok;
      if ((bus.push && full_r) || (bus.pop && empty_r))
        error_r <= 1'b1;
    end
  end

  assign bus.data_out     = q_b;
  assign bus.valid_out    = valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.count        = count_r;
  assign bus.error        = error_r;
endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// Bench for fifo_dpram_ctrl: RAM model, queue-based reference FIFO and a
// scoreboard monitor for popped words.
module tb_fifo_dpram_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       we_a, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b, q_b;
  logic [7:0] mem [64];

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_q [$];
  logic [7:0] exp_q [$];
  bit         ref_err;

  fifo_dpram_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  fifo_dpram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .AF_TH(60), .AE_TH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .we_a   (we_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .we_b   (we_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .q_b    (q_b)
  );

  always #5 clk = ~clk;

  // 64x8 dual-port RAM with registered port-B read
  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
    q_b <= mem[addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a word is due exactly one cycle after its pop was accepted.
  initial begin
    logic [7:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (bus.valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid_out", 32'(bus.valid_out), 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("data_out", 32'(bus.data_out), 32'(w));
        end
      end else if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("missing_valid_out", 32'(bus.valid_out), 32'd1);
      end
    end
  end

  // One clock cycle of stimulus; called just after a falling edge.
  task automatic step(input bit r, input bit p, input bit q, input logic [7:0] d);
    bit pa, qa;
    int n;
    reset       = r;
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    n  = ref_q.size();
    pa = !r && p && (n < 64);
    qa = !r && q && (n > 0);
    #1;
    chk("we_a", 32'(we_a), 32'(pa));
    if (r) begin
      ref_q.delete();
      ref_err = 1'b0;
    end else begin
      if ((p && n == 64) || (q && n == 0)) ref_err = 1'b1;
      if (qa) exp_q.push_back(ref_q.pop_front());
      if (pa) ref_q.push_back(d);
    end
    @(posedge clk);
    #1;
    n = ref_q.size();
    chk("count",        32'(bus.count),        32'(n));
    chk("full",         32'(bus.full),         32'(n == 64));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= 60));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 4));
    chk("error",        32'(bus.error),        32'(ref_err));
    chk("we_b",         32'(we_b),             32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = 8'h00;
    ref_err = 1'b0;
    @(negedge clk);

    // reset with requests asserted
    repeat (2) step(1, 1, 1, 8'hFF);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);

    // fill, then overflow
    for (int i = 0; i < 64; i++) step(0, 1, 0, 8'(i));
    step(0, 1, 0, 8'hAA);

    // drain, then underflow
    for (int i = 0; i < 64; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("valid_after_empty_pop", 32'(bus.valid_out), 32'd0);

    // wrap-around across address 63 -> 0
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 40; i++) step(0, 0, 1, 8'h00);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) step(0, 0, 1, 8'h00);

    // simultaneous push+pop at count 10, then at count 0
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 5; i++)  step(0, 1, 1, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h5A);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // reset mid-operation
    for (int i = 0; i < 30; i++) step(0, 1, 0, 8'(8'hC0 + i));
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // randomized phases, biased to visit both full and empty
    for (int ph = 0; ph < 12; ph++) begin
      int pp;
      pp = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 15 : 50);
      for (int c = 0; c < 150; c++) begin
        bit r;
        r = ($urandom_range(0, 299) == 0);
        step(r, $urandom_range(0, 99) < pp, $urandom_range(0, 99) < (100 - pp),
             8'($urandom_range(0, 255)));
      end
    end

    repeat (3) step(0, 0, 0, 8'h00);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_dpram_ctrl.md
# fifo_dpram_ctrl

Synchronous FIFO controller that acts as the initiator for the team's 64×8 true dual-port RAM. It writes through port A and reads through port B. It turns a push/pop request interface into RAM address, data and write-enable traffic, and tracks occupancy and status flags. It sits between transaction-layer producers/consumers and the RAM instance. The RAM itself stays external so the conductual and structural RAM models can be swapped under the same controller.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; matches RAM data ports.
- ADDR_WIDTH, 6, RAM address width; depth = 2^ADDR_WIDTH = 64.
- AF_TH, 60, almost_full threshold (count ≥ AF_TH).
- AE_TH, 4, almost_empty threshold (count ≤ AE_TH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request; data_in is sampled with it.
- data_in  in  DATA_WIDTH  word to enqueue.
- pop  in  1  read request.
- data_out  out  DATA_WIDTH  dequeued word; meaningful only when valid_out=1.
- valid_out  out  1  data_out carries the word popped in the previous cycle.
- full, empty, almost_full, almost_empty  out  1 each  registered status flags.
- count  out  ADDR_WIDTH+1  current occupancy, 0..64.
- error  out  1  sticky overflow/underflow indicator.
- we_a  out  1  RAM port A write enable.
- addr_a  out  ADDR_WIDTH  RAM port A address (= wr_ptr).
- data_a  out  DATA_WIDTH  RAM port A data (= data_in).
- we_b  out  1  RAM port B write enable; tied 0.
- addr_b  out  ADDR_WIDTH  RAM port B address (= rd_ptr).
- data_b  out  DATA_WIDTH  RAM port B data; tied 0.
- q_b  in  DATA_WIDTH  RAM port B registered read data.

## Operation
- Internal state: wr_ptr, rd_ptr (ADDR_WIDTH bits each), count (ADDR_WIDTH+1 bits), valid_out, error, flags.
- push_ok = push & ~full & ~reset. we_a = push_ok (combinational). addr_a = wr_ptr, data_a = data_in.
- pop_ok = pop & ~empty & ~reset. addr_b = rd_ptr, driven continuously.
- On each edge with push_ok: wr_ptr ← wr_ptr+1, modulo 64 (63→0 wraps naturally).
- On each edge with pop_ok: rd_ptr ← rd_ptr+1, modulo 64.
- count update:
  - count+1 if push_ok only.
  - count−1 if pop_ok only.
  - unchanged if both or neither.
- Flags are registered from next-count:
  - full = (count==64)
  - empty = (count==0)
  - almost_full = (count≥AF_TH)
  - almost_empty = (count≤AE_TH)
- valid_out ← pop_ok. data_out = q_b (RAM registered output, passthrough).
- error ← 1 on (push & full) or (pop & empty). It stays set until reset.
- Rejected requests change no pointer, count or RAM content.
- Push when full is always rejected, even with a simultaneous pop. This avoids a same-address read/write when wr_ptr==rd_ptr.
- Pop when empty is rejected even with a simultaneous push; the push is accepted.
- Simultaneous push_ok and pop_ok when not full/empty: both proceed, addresses differ, count unchanged.

## Timing
- Reset (synchronous, sampled at edge):
  - Pointers = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - valid_out = 0, error = 0.
  - we_a = 0 during the reset cycle.
- RAM contents are not cleared by reset.
- Reset mid-operation discards all queued words. The first cycle after reset behaves as empty.
- Push accepted in cycle N: word is in RAM at edge N. count and flags reflect it from cycle N+1. Earliest pop is cycle N+1.
- Pop accepted in cycle N: RAM captures addr_b at edge N. data_out = q_b and valid_out = 1 during cycle N+1.
- Read latency: 1 cycle. Back-to-back pops give one word per cycle, with valid_out high continuously.
- Flags are never stale by more than zero cycles relative to count. Both update on the same edge.

## Test plan
- Reset: assert reset 2 cycles with push=pop=1 -> empty=1, almost_empty=1, full=0, count=0, error=0, valid_out=0, we_a=0.
- Fill: 64 pushes of 0x00..0x3F -> almost_full rises after the 60th, full=1 and count=64 after the 64th. A 65th push (0xAA) -> we_a=0, count=64, error=1.
- Drain: 64 consecutive pops -> valid_out high for 64 cycles starting one cycle after the first pop, data_out = 0x00..0x3F in order. Then empty=1. A 65th pop -> valid_out=0 next cycle.
- Wrap-around: push 40 (0x10..0x37), pop 40, push 40 (0x80..0xA7), pop 40 -> second batch read in order across address 63→0, count returns to 0.
- Simultaneous: at count=10, push+pop for 5 cycles -> count stays 10 and read order is preserved. At count=0, push 0x5A + pop -> count=1, valid_out=0, error=1. Next pop returns 0x5A.
- Reset mid-operation: at count=30, assert reset 1 cycle -> count=0, empty=1, error=0. Then push 0x11, pop -> data_out=0x11 one cycle after the pop.
